// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: fetch -> S1 (decode, drives imm gen) -> S2 (to execute).
// Two registered stages with valid/ready on both sides and a synchronous flush.
module id_stage_ctrl #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clock_in,
  input  logic               reset_n_in,
  input  logic               flush_in,
  input  logic               fetch_valid_in,
  output logic               fetch_ready_out,
  input  logic [31:0]        fetch_ins_in,
  input  logic [XLEN-1:0]    fetch_pc_in,
  output logic [6:0]         imm_opcode_out,
  output logic [24:0]        imm_ins_out,
  input  logic [31:0]        imm_data_in,
  output logic               exec_valid_out,
  input  logic               exec_ready_in,
  output logic [31:0]        exec_ins_out,
  output logic [XLEN-1:0]    exec_pc_out,
  output logic [31:0]        exec_imm_out,
  output logic               exec_illegal_out,
  output logic [COUNT_W-1:0] dec_count_out
);

  logic            s1_valid;
  logic [31:0]     s1_ins;
  logic [XLEN-1:0] s1_pc;
  logic            s2_valid;
  logic            s2_free;
  logic            s1_adv;
  logic            fetch_hs;
  logic            exec_hs;
  logic            s1_illegal;

  function automatic logic is_illegal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011, 7'b0110111,
      7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011, 7'b1010111: is_illegal = 1'b0;
      default: is_illegal = 1'b1;
    endcase
  endfunction

  assign s2_free         = !s2_valid || exec_ready_in;
  assign s1_adv          = s1_valid && s2_free;
  assign fetch_ready_out = !s1_valid || s2_free;
  assign fetch_hs        = fetch_valid_in && fetch_ready_out;
  assign exec_hs         = s2_valid && exec_ready_in;
  assign exec_valid_out  = s2_valid;
  assign s1_illegal      = is_illegal(s1_ins[6:0]);

  // Imm gen always sees the S1 register, never the raw fetch bus.
  assign imm_opcode_out = s1_ins[6:0];
  assign imm_ins_out    = s1_ins[31:7];

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      s1_valid <= 1'b0;
      s1_ins   <= '0;
      s1_pc    <= '0;
    end else if (flush_in) begin
      s1_valid <= 1'b0;
    end else if (fetch_hs) begin
      s1_valid <= 1'b1;
      s1_ins   <= fetch_ins_in;
      s1_pc    <= fetch_pc_in;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      s2_valid         <= 1'b0;
      exec_ins_out     <= '0;
      exec_pc_out      <= '0;
      exec_imm_out     <= '0;
      exec_illegal_out <= 1'b0;
    end else if (flush_in) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid         <= 1'b1;
      exec_ins_out     <= s1_ins;
      exec_pc_out      <= s1_pc;
      exec_imm_out     <= imm_data_in;
      exec_illegal_out <= s1_illegal;
    end else if (exec_hs) begin
      s2_valid <= 1'b0;
    end
  end

  // A handshake coinciding with flush still completed, so it still counts.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      dec_count_out <= '0;
    end else if (exec_hs) begin
      dec_count_out <= dec_count_out + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Scoreboard bench for id_stage_ctrl: stimulus pushes expected instructions,
// a negedge monitor pops and checks whatever execute sees.
module tb_id_stage_ctrl;
  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            fv = 1'b0;
  logic            fetch_ready;
  logic [31:0]     fins = '0;
  logic [XLEN-1:0] fpc = '0;
  logic [6:0]      imm_op;
  logic [24:0]     imm_ins;
  logic [31:0]     imm_data;
  logic            exec_valid;
  logic            er = 1'b0;
  logic [31:0]     exec_ins;
  logic [XLEN-1:0] exec_pc;
  logic [31:0]     exec_imm;
  logic            exec_ill;
  logic [CW-1:0]   dec_count;

  always #5 clk = ~clk;

  id_stage_ctrl #(.XLEN(XLEN), .COUNT_W(CW)) dut (
    .clock_in(clk), .reset_n_in(rst_n), .flush_in(flush),
    .fetch_valid_in(fv), .fetch_ready_out(fetch_ready),
    .fetch_ins_in(fins), .fetch_pc_in(fpc),
    .imm_opcode_out(imm_op), .imm_ins_out(imm_ins), .imm_data_in(imm_data),
    .exec_valid_out(exec_valid), .exec_ready_in(er),
    .exec_ins_out(exec_ins), .exec_pc_out(exec_pc), .exec_imm_out(exec_imm),
    .exec_illegal_out(exec_ill), .dec_count_out(dec_count)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        ill;
    int          acc_edge;
  } item_t;

  item_t         q[$];
  int            errors = 0;
  int            checks = 0;
  int            edge_cnt = 0;
  logic [CW-1:0] cnt_m = '0;
  logic          vexp;
  logic [6:0]    legal_ops [11] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011,
                                    7'b0110011, 7'b0110111, 7'b1100011, 7'b1100111,
                                    7'b1101111, 7'b1110011, 7'b1010111};

  function automatic logic [31:0] imm_fn(input logic [31:0] i);
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return {{20{i[31]}}, i[31:20]};
      7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: return {i[31:12], 12'b0};
      7'b1101111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic is_ill(input logic [31:0] i);
    foreach (legal_ops[k]) if (legal_ops[k] == i[6:0]) return 1'b0;
    return 1'b1;
  endfunction

  // External immediate generator, fed only by the DUT's S1 outputs.
  assign imm_data = imm_fn({imm_ins, imm_op});

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an item is visible to execute once it has spent one edge in S1.
  always @(negedge clk) begin
    #2;
    vexp = (q.size() > 0) && (q[0].acc_edge < edge_cnt);
    chk("fetch_ready", 32'(fetch_ready), 32'(!(q.size() >= 2 && !er)));
    chk("exec_valid", 32'(exec_valid), 32'(vexp));
    chk("dec_count", 32'(dec_count), 32'(cnt_m));
    if (vexp) begin
      chk("exec_ins", exec_ins, q[0].ins);
      chk("exec_pc", exec_pc, q[0].pc);
      chk("exec_imm", exec_imm, q[0].imm);
      chk("exec_illegal", 32'(exec_ill), 32'(q[0].ill));
      if (er && rst_n) begin
        void'(q.pop_front());
        cnt_m++;
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic r, input logic fl, output bit acc);
    @(negedge clk);
    fv = v; fins = ins; fpc = pc; er = r; flush = fl;
    #3;
    acc = v && fetch_ready && rst_n;
    if (fl) q.delete();
    else if (acc) q.push_back('{ins, pc, imm_fn(ins), is_ill(ins), edge_cnt + 1});
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; er = 1'b1; fv = 1'b1; fins = 32'h00000013;
    #1;
    q.delete();
    cnt_m = '0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1; fv = 1'b0;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(3) != 0) r[6:0] = legal_ops[$urandom_range(10)];
    return r;
  endfunction

  initial begin
    bit          a;
    int          k;
    logic [31:0] pend_ins;
    logic [31:0] pend_pc;
    bit          pend;

    do_reset(3);
    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0, a);
    repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);

    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h00100093 + (i << 20), 32'h200 + 4 * i, 1'b1, 1'b0, a);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);

    k = 0;
    for (int c = 0; c < 16; c++) begin
      step(k < 8, 32'h00000033 + (k << 7), 32'h300 + 4 * k, !(c >= 2 && c < 6), 1'b0, a);
      if (a) k++;
    end
    chk("stall_stream_done", 32'(k), 32'd8);

    step(1'b1, 32'h00000033, 32'h500, 1'b0, 1'b0, a);
    step(1'b1, 32'h0000007F, 32'h504, 1'b0, 1'b0, a);
    step(1'b1, 32'h00000013, 32'h508, 1'b1, 1'b1, a);
    step(1'b1, 32'h0000007F, 32'h600, 1'b1, 1'b0, a);
    step(1'b1, 32'h12345037, 32'h604, 1'b0, 1'b0, a);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, a);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);

    pend = 1'b0; pend_ins = '0; pend_pc = '0;
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        do_reset(2);
        pend = 1'b0;
      end
      if (!pend && $urandom_range(9) < 7) begin
        pend = 1'b1; pend_ins = rand_ins(); pend_pc = $urandom() & 32'hFFFF_FFFC;
      end
      step(pend, pend_ins, pend_pc, $urandom_range(9) < 7, $urandom_range(99) < 3, a);
      if (a) pend = 1'b0;
    end
    repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    chk("drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
